// File: rtl/defs_sb.sv
// Shared definitions for the writeback scoreboard slice: sizes, writeback-source
// encoding, writeback payload and a saturating popcount helper.
package defs_sb;

    localparam int unsigned NREG     = 4;
    localparam int unsigned RIDX_W   = 2;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_PEND = 3;
    localparam int unsigned PCNT_W   = 2;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_LD   = 2'd1,
        WB_SRC_ALU  = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [RIDX_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } wb_payload_t;

    // Number of set bits, clamped to MAX_PEND.
    function automatic logic [PCNT_W-1:0] sat_popcount(input logic [NREG-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < NREG; i++) begin
            n += 32'(v[i]);
        end
        return (n > MAX_PEND) ? PCNT_W'(MAX_PEND) : PCNT_W'(n);
    endfunction

endpackage

// File: rtl/wb_scoreboard_if.sv
// Decode / writeback / register-file bundle around the scoreboard.
// With SCOREBOARD_BYPASS_EN defined, forwarding signals are added.
interface wb_scoreboard_if;
    import defs_sb::*;

    logic              dec_valid;
    logic              dec_rs_en;
    logic [RIDX_W-1:0] dec_rs;
    logic              dec_rt_en;
    logic [RIDX_W-1:0] dec_rt;
    logic              dec_rd_en;
    logic [RIDX_W-1:0] dec_rd;
    logic              dec_stall;

    logic              alu_wb_valid;
    logic [RIDX_W-1:0] alu_wb_idx;
    logic [DATA_W-1:0] alu_wb_data;
    logic              alu_wb_stall;

    logic              ld_wb_valid;
    logic [RIDX_W-1:0] ld_wb_idx;
    logic [DATA_W-1:0] ld_wb_data;

    logic              rf_we;
    logic [RIDX_W-1:0] rf_idx;
    logic [DATA_W-1:0] rf_wdata;

    logic [NREG-1:0]   reserved;
    logic [PCNT_W-1:0] pend_cnt;
    logic              wb_err;

`ifdef SCOREBOARD_BYPASS_EN
    logic              fwd_rs_hit;
    logic              fwd_rt_hit;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output dec_valid, dec_rs_en, dec_rs, dec_rt_en, dec_rt, dec_rd_en, dec_rd,
        output alu_wb_valid, alu_wb_idx, alu_wb_data,
        output ld_wb_valid, ld_wb_idx, ld_wb_data,
        input  dec_stall, alu_wb_stall, rf_we, rf_idx, rf_wdata,
        input  reserved, pend_cnt, wb_err,
        input  fwd_rs_hit, fwd_rt_hit, fwd_data
    );

    modport slave (
        input  dec_valid, dec_rs_en, dec_rs, dec_rt_en, dec_rt, dec_rd_en, dec_rd,
        input  alu_wb_valid, alu_wb_idx, alu_wb_data,
        input  ld_wb_valid, ld_wb_idx, ld_wb_data,
        output dec_stall, alu_wb_stall, rf_we, rf_idx, rf_wdata,
        output reserved, pend_cnt, wb_err,
        output fwd_rs_hit, fwd_rt_hit, fwd_data
    );
`else
    modport master (
        output dec_valid, dec_rs_en, dec_rs, dec_rt_en, dec_rt, dec_rd_en, dec_rd,
        output alu_wb_valid, alu_wb_idx, alu_wb_data,
        output ld_wb_valid, ld_wb_idx, ld_wb_data,
        input  dec_stall, alu_wb_stall, rf_we, rf_idx, rf_wdata,
        input  reserved, pend_cnt, wb_err
    );

    modport slave (
        input  dec_valid, dec_rs_en, dec_rs, dec_rt_en, dec_rt, dec_rd_en, dec_rd,
        input  alu_wb_valid, alu_wb_idx, alu_wb_data,
        input  ld_wb_valid, ld_wb_idx, ld_wb_data,
        output dec_stall, alu_wb_stall, rf_we, rf_idx, rf_wdata,
        output reserved, pend_cnt, wb_err
    );
`endif

endinterface

// File: rtl/wb_scoreboard_arbiter.sv
// Fixed-priority writeback arbiter: the load (older) beats the ALU; purely
// combinational grant plus payload mux.
module wb_arbiter
    import defs_sb::*;
(
    input  logic        ld_valid,
    input  wb_payload_t ld_pl,
    input  logic        alu_valid,
    input  wb_payload_t alu_pl,
    output wb_src_e     src_c,
    output wb_payload_t pl_c,
    output logic        alu_stall_c
);

    always_comb begin
        src_c       = WB_SRC_NONE;
        pl_c        = '0;
        alu_stall_c = 1'b0;
        if (ld_valid) begin
            src_c       = WB_SRC_LD;
            pl_c        = ld_pl;
            alu_stall_c = alu_valid;
        end else if (alu_valid) begin
            src_c = WB_SRC_ALU;
            pl_c  = alu_pl;
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Register-hazard scoreboard and shared register-file write port.
// Optional SCOREBOARD_BYPASS_EN: same-cycle writeback clears the hazard and forwards data.
module wb_scoreboard
    import defs_sb::*;
(
    input  logic           clk,
    input  logic           rst,
    wb_scoreboard_if.slave sb
);

    logic [NREG-1:0]   reserved_q;
    logic [NREG-1:0]   reserved_d;
    logic [PCNT_W-1:0] pend_q;
    logic              wb_err_q;

    wb_src_e     wb_src;
    wb_payload_t wb_pl;
    wb_payload_t ld_pl;
    wb_payload_t alu_pl;

    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] busy_vec;
    logic            hazard;
    logic            issue;

    assign ld_pl  = '{idx: sb.ld_wb_idx,  data: sb.ld_wb_data};
    assign alu_pl = '{idx: sb.alu_wb_idx, data: sb.alu_wb_data};

    wb_arbiter u_arb (
        .ld_valid    (sb.ld_wb_valid),
        .ld_pl       (ld_pl),
        .alu_valid   (sb.alu_wb_valid),
        .alu_pl      (alu_pl),
        .src_c       (wb_src),
        .pl_c        (wb_pl),
        .alu_stall_c (sb.alu_wb_stall)
    );

    assign sb.rf_we    = (wb_src != WB_SRC_NONE);
    assign sb.rf_idx   = wb_pl.idx;
    assign sb.rf_wdata = wb_pl.data;

    assign clr_vec = sb.rf_we ? (NREG'(1) << sb.rf_idx) : '0;

`ifdef SCOREBOARD_BYPASS_EN
    // A register written this cycle is already available to decode.
    assign busy_vec      = reserved_q & ~clr_vec;
    assign sb.fwd_rs_hit = sb.rf_we & sb.dec_rs_en & (sb.rf_idx == sb.dec_rs);
    assign sb.fwd_rt_hit = sb.rf_we & sb.dec_rt_en & (sb.rf_idx == sb.dec_rt);
    assign sb.fwd_data   = sb.rf_wdata;
`else
    assign busy_vec = reserved_q;
`endif

    always_comb begin
        hazard = (sb.dec_rs_en & busy_vec[sb.dec_rs])
               | (sb.dec_rt_en & busy_vec[sb.dec_rt])
               | (sb.dec_rd_en & busy_vec[sb.dec_rd])
               | (sb.dec_rd_en & (pend_q == PCNT_W'(MAX_PEND)));
    end

    assign sb.dec_stall = sb.dec_valid & hazard;
    assign issue        = sb.dec_valid & ~hazard & sb.dec_rd_en;
    assign set_vec      = issue ? (NREG'(1) << sb.dec_rd) : '0;

    // Set wins over clear so a bypassed WAW issue keeps its new reservation.
    assign reserved_d = (reserved_q & ~clr_vec) | set_vec;

    always_ff @(posedge clk) begin
        if (!rst) begin
            reserved_q <= '0;
            pend_q     <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            reserved_q <= reserved_d;
            pend_q     <= sat_popcount(reserved_d);
            if (sb.rf_we && !reserved_q[sb.rf_idx]) begin
                wb_err_q <= 1'b1;
            end
        end
    end

    assign sb.reserved = reserved_q;
    assign sb.pend_cnt = pend_q;
    assign sb.wb_err   = wb_err_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: reset, RAW, arbitration, pending limit, WAW, error.
// Follows SCOREBOARD_BYPASS_EN to pick the expected RAW/WAW timing.
module tb_wb_scoreboard;
    import defs_sb::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    wb_scoreboard_if bus ();

    wb_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic dec_idle();
        bus.dec_valid = 1'b0;
        bus.dec_rs_en = 1'b0;
        bus.dec_rs    = '0;
        bus.dec_rt_en = 1'b0;
        bus.dec_rt    = '0;
        bus.dec_rd_en = 1'b0;
        bus.dec_rd    = '0;
    endtask

    task automatic dec_write(input logic [RIDX_W-1:0] rd);
        dec_idle();
        bus.dec_valid = 1'b1;
        bus.dec_rd_en = 1'b1;
        bus.dec_rd    = rd;
    endtask

    task automatic ld_drive(input logic v, input logic [RIDX_W-1:0] idx, input logic [DATA_W-1:0] d);
        bus.ld_wb_valid = v;
        bus.ld_wb_idx   = idx;
        bus.ld_wb_data  = d;
    endtask

    task automatic alu_drive(input logic v, input logic [RIDX_W-1:0] idx, input logic [DATA_W-1:0] d);
        bus.alu_wb_valid = v;
        bus.alu_wb_idx   = idx;
        bus.alu_wb_data  = d;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst   = 1'b0;
        dec_idle();
        ld_drive(1'b0, '0, '0);
        alu_drive(1'b0, '0, '0);

        // Reset
        tick();
        tick();
        chk("rst_reserved", 32'(bus.reserved), 32'h0);
        chk("rst_pend",     32'(bus.pend_cnt), 32'h0);
        chk("rst_wb_err",   32'(bus.wb_err),   32'h0);
        chk("rst_rf_we",    32'(bus.rf_we),    32'h0);
        chk("rst_stall",    32'(bus.dec_stall), 32'h0);
        rst = 1'b1;
        tick();

        // RAW on r1
        dec_write(2'd1);
        settle();
        chk("raw_issue_stall", 32'(bus.dec_stall), 32'h0);
        tick();
        dec_idle();
        bus.dec_valid = 1'b1;
        bus.dec_rs_en = 1'b1;
        bus.dec_rs    = 2'd1;
        settle();
        chk("raw_reserved", 32'(bus.reserved), 32'h2);
        chk("raw_pend",     32'(bus.pend_cnt), 32'h1);
        chk("raw_stall0",   32'(bus.dec_stall), 32'h1);
        tick();
        chk("raw_stall1",   32'(bus.dec_stall), 32'h1);
        alu_drive(1'b1, 2'd1, 32'h0000_00AA);
        settle();
        chk("raw_rf_we",    32'(bus.rf_we),    32'h1);
        chk("raw_rf_idx",   32'(bus.rf_idx),   32'h1);
        chk("raw_rf_data",  32'(bus.rf_wdata), 32'h0000_00AA);
        chk("raw_alu_stall", 32'(bus.alu_wb_stall), 32'h0);
`ifdef SCOREBOARD_BYPASS_EN
        chk("raw_wb_stall", 32'(bus.dec_stall),  32'h0);
        chk("raw_fwd_hit",  32'(bus.fwd_rs_hit), 32'h1);
        chk("raw_fwd_data", 32'(bus.fwd_data),   32'h0000_00AA);
`else
        chk("raw_wb_stall", 32'(bus.dec_stall), 32'h1);
`endif
        tick();
        alu_drive(1'b0, '0, '0);
        settle();
        chk("raw_after_stall", 32'(bus.dec_stall), 32'h0);
        chk("raw_after_res",   32'(bus.reserved),  32'h0);
        tick();
        dec_idle();

        // Arbitration: load beats ALU
        dec_write(2'd2);
        tick();
        dec_write(2'd3);
        tick();
        dec_idle();
        chk("arb_reserved", 32'(bus.reserved), 32'hC);
        chk("arb_pend",     32'(bus.pend_cnt), 32'h2);
        ld_drive(1'b1, 2'd2, 32'h11);
        alu_drive(1'b1, 2'd3, 32'h22);
        settle();
        chk("arb_ld_we",    32'(bus.rf_we),        32'h1);
        chk("arb_ld_idx",   32'(bus.rf_idx),       32'h2);
        chk("arb_ld_data",  32'(bus.rf_wdata),     32'h11);
        chk("arb_alu_held", 32'(bus.alu_wb_stall), 32'h1);
        tick();
        ld_drive(1'b0, '0, '0);
        settle();
        chk("arb_res_mid",  32'(bus.reserved),     32'h8);
        chk("arb_alu_idx",  32'(bus.rf_idx),       32'h3);
        chk("arb_alu_data", 32'(bus.rf_wdata),     32'h22);
        chk("arb_alu_go",   32'(bus.alu_wb_stall), 32'h0);
        tick();
        alu_drive(1'b0, '0, '0);
        chk("arb_res_end",  32'(bus.reserved), 32'h0);
        chk("arb_pend_end", 32'(bus.pend_cnt), 32'h0);
        chk("arb_no_err",   32'(bus.wb_err),   32'h0);

        // Pending limit
        for (int i = 0; i < 3; i++) begin
            dec_write(RIDX_W'(i));
            tick();
        end
        dec_idle();
        chk("lim_reserved", 32'(bus.reserved), 32'h7);
        chk("lim_pend",     32'(bus.pend_cnt), 32'h3);
        dec_write(2'd3);
        settle();
        chk("lim_stall0", 32'(bus.dec_stall), 32'h1);
        tick();
        alu_drive(1'b1, 2'd0, 32'h5);
        settle();
        chk("lim_stall_wb", 32'(bus.dec_stall), 32'h1);
        tick();
        alu_drive(1'b0, '0, '0);
        settle();
        chk("lim_pend_dn", 32'(bus.pend_cnt),  32'h2);
        chk("lim_go",      32'(bus.dec_stall), 32'h0);
        tick();
        dec_idle();
        chk("lim_res_end",  32'(bus.reserved), 32'hE);
        chk("lim_pend_end", 32'(bus.pend_cnt), 32'h3);

        // Drain r1 and r3, leaving r2 reserved
        ld_drive(1'b1, 2'd1, 32'h1);
        tick();
        ld_drive(1'b1, 2'd3, 32'h3);
        tick();
        ld_drive(1'b0, '0, '0);
        chk("waw_res_pre", 32'(bus.reserved), 32'h4);
        chk("waw_pend_pre", 32'(bus.pend_cnt), 32'h1);

        // WAW on r2
        dec_write(2'd2);
        settle();
        chk("waw_stall0", 32'(bus.dec_stall), 32'h1);
        tick();
        ld_drive(1'b1, 2'd2, 32'h33);
        settle();
`ifdef SCOREBOARD_BYPASS_EN
        chk("waw_wb_stall", 32'(bus.dec_stall), 32'h0);
        tick();
        ld_drive(1'b0, '0, '0);
        dec_idle();
`else
        chk("waw_wb_stall", 32'(bus.dec_stall), 32'h1);
        tick();
        ld_drive(1'b0, '0, '0);
        settle();
        chk("waw_go", 32'(bus.dec_stall), 32'h0);
        tick();
        dec_idle();
`endif
        chk("waw_res_new", 32'(bus.reserved), 32'h4);
        ld_drive(1'b1, 2'd2, 32'h44);
        tick();
        ld_drive(1'b0, '0, '0);
        chk("waw_res_end", 32'(bus.reserved), 32'h0);
        chk("waw_no_err",  32'(bus.wb_err),   32'h0);

        // Writeback to an unreserved register
        alu_drive(1'b1, 2'd0, 32'h77);
        settle();
        chk("err_rf_we", 32'(bus.rf_we), 32'h1);
        tick();
        alu_drive(1'b0, '0, '0);
        chk("err_set", 32'(bus.wb_err), 32'h1);
        tick();
        tick();
        chk("err_sticky", 32'(bus.wb_err), 32'h1);
        rst = 1'b0;
        tick();
        chk("err_clear", 32'(bus.wb_err), 32'h0);
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
